// File: rtl/cu_read_cmd_generator_if.sv
// Signal bundle between a compute unit's read-command generator and its job source,
// the AFU read command buffer and the read-response credit return path.
interface cu_read_cmd_generator_if #(
  parameter int SIZE_W = 32
);
  logic              enabled_in;
  logic              job_valid_in;
  logic              job_ready_out;
  logic [63:0]       job_addr_in;
  logic [SIZE_W-1:0] job_size_in;
  logic              cmd_valid_out;
  logic              cmd_ready_in;
  logic [63:0]       cmd_addr_out;
  logic [7:0]        cmd_cu_id_out;
  logic              rsp_valid_in;
  logic [6:0]        credits_out;
  logic              busy_out;
  logic              done_out;
  logic              error_out;

  // Generator side.
  modport slave (
    input  enabled_in, job_valid_in, job_addr_in, job_size_in, cmd_ready_in, rsp_valid_in,
    output job_ready_out, cmd_valid_out, cmd_addr_out, cmd_cu_id_out, credits_out,
    output busy_out, done_out, error_out
  );

  // Job source / command sink side.
  modport master (
    output enabled_in, job_valid_in, job_addr_in, job_size_in, cmd_ready_in, rsp_valid_in,
    input  job_ready_out, cmd_valid_out, cmd_addr_out, cmd_cu_id_out, credits_out,
    input  busy_out, done_out, error_out
  );
endinterface

// File: rtl/cu_read_cmd_generator.sv
// Splits a (byte address, byte size) read job into cacheline read commands, throttled by a
// local credit pool that is refilled by one credit per returned read response.
module cu_read_cmd_generator #(
  parameter logic [7:0] CU_ID    = 8'h01,
  parameter int         CREDITS  = 32,
  parameter int         CL_BYTES = 128,
  parameter int         SIZE_W   = 32
) (
  input  logic               clock,
  input  logic               rstn,
  cu_read_cmd_generator_if.slave bus
);
  localparam int              CL_W         = $clog2(CL_BYTES);
  localparam int              W1           = SIZE_W + 1;
  localparam logic [63:0]     CL_MASK      = 64'(CL_BYTES - 1);
  localparam logic [63:0]     CL_STEP      = 64'(CL_BYTES);
  localparam logic [W1-1:0]   CL_ROUND     = W1'(CL_BYTES - 1);
  localparam logic [6:0]      CREDITS_INIT = 7'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [63:0]     addr_reg, addr_next;
  logic [W1-1:0]   remaining_reg, remaining_next;
  logic [6:0]      credits_reg, credits_next;
  logic [6:0]      outstanding_reg, outstanding_next;
  logic            hold_reg, hold_next;
  logic            error_reg, error_next;
  logic            job_fire, cmd_valid, cmd_fire, rsp_ok;
  logic [W1-1:0]   lines_needed;

  // Cachelines touched by [addr, addr+size-1]; the extra bit absorbs the rounding carry.
  always_comb begin
    lines_needed = (W1'({1'b0, bus.job_size_in}) + W1'(bus.job_addr_in & CL_MASK) + CL_ROUND) >> CL_W;
  end

  always_comb begin
    job_fire  = (state_reg == S_IDLE) && bus.enabled_in && bus.job_valid_in;
    cmd_valid = (state_reg == S_ISSUE) &&
                (hold_reg || (bus.enabled_in && (credits_reg != 7'd0) && (remaining_reg != '0)));
    cmd_fire  = cmd_valid && bus.cmd_ready_in;
    rsp_ok    = bus.rsp_valid_in && (outstanding_reg != 7'd0);
  end

  // Credit bookkeeping: an issue and a response in the same cycle cancel out.
  always_comb begin
    credits_next     = credits_reg;
    outstanding_next = outstanding_reg;
    if (cmd_fire && !rsp_ok) begin
      credits_next     = credits_reg - 7'd1;
      outstanding_next = outstanding_reg + 7'd1;
    end else if (!cmd_fire && rsp_ok) begin
      credits_next     = credits_reg + 7'd1;
      outstanding_next = outstanding_reg - 7'd1;
    end
    error_next = error_reg | (bus.rsp_valid_in && (outstanding_reg == 7'd0));
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    hold_next      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (job_fire) begin
          addr_next = bus.job_addr_in & ~CL_MASK;
          if (bus.job_size_in == '0) begin
            remaining_next = '0;
            state_next     = S_DONE;
          end else begin
            remaining_next = lines_needed;
            state_next     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A presented command stays presented until taken, even if enabled_in drops.
        hold_next = cmd_valid && !bus.cmd_ready_in;
        if (cmd_fire) begin
          addr_next      = addr_reg + CL_STEP;
          remaining_next = remaining_reg - W1'(1);
          if (remaining_reg == W1'(1)) begin
            state_next = S_DRAIN;
          end
        end
      end
      // Leave as soon as the response that clears the last outstanding command arrives.
      S_DRAIN: begin
        if (outstanding_next == 7'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= S_IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      credits_reg     <= CREDITS_INIT;
      outstanding_reg <= 7'd0;
      hold_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      remaining_reg   <= remaining_next;
      credits_reg     <= credits_next;
      outstanding_reg <= outstanding_next;
      hold_reg        <= hold_next;
      error_reg       <= error_next;
    end
  end

  assign bus.job_ready_out = (state_reg == S_IDLE) && bus.enabled_in;
  assign bus.cmd_valid_out = cmd_valid;
  assign bus.cmd_addr_out  = addr_reg;
  assign bus.cmd_cu_id_out = CU_ID;
  assign bus.credits_out   = credits_reg;
  assign bus.busy_out      = (state_reg != S_IDLE);
  assign bus.done_out      = (state_reg == S_DONE);
  assign bus.error_out     = error_reg;
endmodule

// File: tb/tb_cu_read_cmd_generator.sv
// Directed bench for cu_read_cmd_generator: a per-cycle scoreboard of expected cacheline
// addresses and credit counts, plus hand-computed checks for each directed scenario.
module tb_cu_read_cmd_generator;
  localparam logic [7:0] CU_ID   = 8'h5A;
  localparam int         CREDITS = 32;

  logic clock;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  cu_read_cmd_generator_if #(.SIZE_W(32)) bus ();

  cu_read_cmd_generator #(
    .CU_ID(CU_ID), .CREDITS(CREDITS), .CL_BYTES(128), .SIZE_W(32)
  ) dut (
    .clock(clock),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  logic [63:0] exp_q[$];
  int          m_credits = CREDITS;
  int          m_out     = 0;
  bit          m_err     = 1'b0;
  bit          prev_hold = 1'b0;
  bit          prev_done = 1'b0;
  logic [63:0] prev_addr = '0;
  int          xfer_count = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (!rstn) begin
        exp_q.delete();
        m_credits = CREDITS;
        m_out     = 0;
        m_err     = 1'b0;
        prev_hold = 1'b0;
        prev_done = 1'b0;
      end else begin
        bit fire;
        bit rsp_counts;
        chk("sb_credits", 64'(bus.credits_out), 64'(m_credits));
        chk("sb_error", 64'(bus.error_out), 64'(m_err));
        chk("sb_cu_id", 64'(bus.cmd_cu_id_out), 64'(CU_ID));
        if (prev_hold) begin
          chk("sb_hold_valid", 64'(bus.cmd_valid_out), 64'd1);
          chk("sb_hold_addr", bus.cmd_addr_out, prev_addr);
        end
        if (prev_done) chk("sb_done_pulse", 64'(bus.done_out), 64'd0);
        if (bus.cmd_valid_out) begin
          chk("sb_valid_has_credit", 64'(m_credits > 0), 64'd1);
          chk("sb_valid_has_line", 64'(exp_q.size() > 0), 64'd1);
        end
        if (bus.job_valid_in && bus.job_ready_out && bus.job_size_in != 0) begin
          logic [63:0] first_cl;
          logic [63:0] last_cl;
          first_cl = bus.job_addr_in & ~64'h7F;
          last_cl  = (bus.job_addr_in + 64'(bus.job_size_in) - 64'd1) & ~64'h7F;
          for (int n = 0; n < 4096; n++) begin
            exp_q.push_back(first_cl + 64'(n) * 64'd128);
            if (first_cl + 64'(n) * 64'd128 == last_cl) break;
          end
        end
        fire       = bus.cmd_valid_out && bus.cmd_ready_in;
        rsp_counts = bus.rsp_valid_in && (m_out > 0);
        if (bus.rsp_valid_in && m_out == 0) m_err = 1'b1;
        if (fire) begin
          xfer_count++;
          if (exp_q.size() == 0) chk("sb_extra_cmd", bus.cmd_addr_out, 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("sb_cmd_addr", bus.cmd_addr_out, exp_q.pop_front());
          m_credits--;
          m_out++;
        end
        if (rsp_counts) begin
          m_credits++;
          m_out--;
        end
        prev_hold = bus.cmd_valid_out && !bus.cmd_ready_in;
        prev_addr = bus.cmd_addr_out;
        prev_done = bus.done_out;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_slot();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) next_slot();
  endtask

  task automatic job(input logic [63:0] a, input logic [31:0] s);
    bus.job_valid_in = 1'b1;
    bus.job_addr_in  = a;
    bus.job_size_in  = s;
    @(negedge clock);
    chk("job_ready", 64'(bus.job_ready_out), 64'd1);
    next_slot();
    bus.job_valid_in = 1'b0;
  endtask

  task automatic expect_cmd(input logic [63:0] a);
    @(negedge clock);
    chk("cmd_valid", 64'(bus.cmd_valid_out), 64'd1);
    chk("cmd_addr", bus.cmd_addr_out, a);
    next_slot();
  endtask

  task automatic expect_no_cmd();
    @(negedge clock);
    chk("cmd_idle", 64'(bus.cmd_valid_out), 64'd0);
    next_slot();
  endtask

  task automatic rsps(input int n);
    bus.rsp_valid_in = 1'b1;
    run(n);
    bus.rsp_valid_in = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.done_out) begin
        seen = 1'b1;
        break;
      end
      next_slot();
    end
    chk("done_seen", 64'(seen), 64'd1);
    next_slot();
    @(negedge clock);
    chk("done_cleared", 64'(bus.done_out), 64'd0);
    chk("idle_after_done", 64'(bus.busy_out), 64'd0);
    next_slot();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    rstn             = 1'b0;
    bus.enabled_in   = 1'b0;
    bus.job_valid_in = 1'b0;
    bus.job_addr_in  = '0;
    bus.job_size_in  = '0;
    bus.cmd_ready_in = 1'b0;
    bus.rsp_valid_in = 1'b0;

    @(negedge clock);
    chk("rst_job_ready", 64'(bus.job_ready_out), 64'd0);
    chk("rst_cmd_valid", 64'(bus.cmd_valid_out), 64'd0);
    chk("rst_cmd_addr", bus.cmd_addr_out, 64'd0);
    chk("rst_cu_id", 64'(bus.cmd_cu_id_out), 64'(CU_ID));
    chk("rst_credits", 64'(bus.credits_out), 64'd32);
    chk("rst_busy", 64'(bus.busy_out), 64'd0);
    chk("rst_done", 64'(bus.done_out), 64'd0);
    chk("rst_error", 64'(bus.error_out), 64'd0);
    next_slot();
    rstn             = 1'b1;
    bus.enabled_in   = 1'b1;
    bus.cmd_ready_in = 1'b1;
    next_slot();

    // Aligned 4-line job, back-to-back commands, done right after the last response.
    job(64'h1000, 32'd512);
    expect_cmd(64'h1000);
    expect_cmd(64'h1080);
    expect_cmd(64'h1100);
    expect_cmd(64'h1180);
    @(negedge clock);
    chk("j1_no_5th", 64'(bus.cmd_valid_out), 64'd0);
    chk("j1_credits", 64'(bus.credits_out), 64'd28);
    chk("j1_busy", 64'(bus.busy_out), 64'd1);
    next_slot();
    bus.rsp_valid_in = 1'b1;
    run(3);
    @(negedge clock);
    chk("j1_done_early", 64'(bus.done_out), 64'd0);
    next_slot();
    bus.rsp_valid_in = 1'b0;
    @(negedge clock);
    chk("j1_done", 64'(bus.done_out), 64'd1);
    next_slot();
    @(negedge clock);
    chk("j1_done_once", 64'(bus.done_out), 64'd0);
    chk("j1_credits_back", 64'(bus.credits_out), 64'd32);
    next_slot();

    // Unaligned jobs.
    job(64'h1050, 32'h40);
    expect_cmd(64'h1000);
    expect_cmd(64'h1080);
    expect_no_cmd();
    rsps(2);
    wait_done();

    job(64'h107F, 32'd1);
    expect_cmd(64'h1000);
    expect_no_cmd();
    rsps(1);
    wait_done();

    // 40-line job with no responses: the credit pool caps issue at 32.
    job(64'h0, 32'd5120);
    base = xfer_count;
    run(40);
    @(negedge clock);
    chk("cr_issued_32", 64'(xfer_count - base), 64'd32);
    chk("cr_valid_low", 64'(bus.cmd_valid_out), 64'd0);
    chk("cr_zero", 64'(bus.credits_out), 64'd0);
    next_slot();
    bus.rsp_valid_in = 1'b1;
    next_slot();
    bus.rsp_valid_in = 1'b0;
    run(4);
    @(negedge clock);
    chk("cr_one_more", 64'(xfer_count - base), 64'd33);
    chk("cr_zero_again", 64'(bus.credits_out), 64'd0);
    next_slot();
    bus.rsp_valid_in = 1'b1;
    next_slot();
    @(negedge clock);
    chk("same_cycle_valid", 64'(bus.cmd_valid_out), 64'd1);
    chk("same_cycle_before", 64'(bus.credits_out), 64'd1);
    next_slot();
    bus.rsp_valid_in = 1'b0;
    @(negedge clock);
    chk("same_cycle_after", 64'(bus.credits_out), 64'd1);
    next_slot();
    rsps(37);
    wait_done();
    chk("cr_total_40", 64'(xfer_count - base), 64'd40);

    // Back-pressure with enabled_in dropped while a command is presented.
    bus.cmd_ready_in = 1'b0;
    job(64'h2000, 32'd256);
    @(negedge clock);
    chk("bp_valid", 64'(bus.cmd_valid_out), 64'd1);
    chk("bp_addr", bus.cmd_addr_out, 64'h2000);
    next_slot();
    bus.enabled_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_hold_valid", 64'(bus.cmd_valid_out), 64'd1);
      chk("bp_hold_addr", bus.cmd_addr_out, 64'h2000);
      next_slot();
    end
    bus.cmd_ready_in = 1'b1;
    expect_cmd(64'h2000);
    @(negedge clock);
    chk("bp_paused", 64'(bus.cmd_valid_out), 64'd0);
    chk("bp_busy", 64'(bus.busy_out), 64'd1);
    next_slot();
    bus.enabled_in = 1'b1;
    expect_cmd(64'h2080);
    expect_no_cmd();
    rsps(2);
    wait_done();

    // Zero-size job: no command, done on the following cycle.
    job(64'h3000, 32'd0);
    @(negedge clock);
    chk("z_done", 64'(bus.done_out), 64'd1);
    chk("z_no_cmd", 64'(bus.cmd_valid_out), 64'd0);
    next_slot();
    @(negedge clock);
    chk("z_done_once", 64'(bus.done_out), 64'd0);
    chk("z_idle", 64'(bus.busy_out), 64'd0);
    next_slot();

    // Spurious response with nothing outstanding.
    bus.rsp_valid_in = 1'b1;
    next_slot();
    bus.rsp_valid_in = 1'b0;
    @(negedge clock);
    chk("sp_error", 64'(bus.error_out), 64'd1);
    chk("sp_credits", 64'(bus.credits_out), 64'd32);
    run(3);
    @(negedge clock);
    chk("sp_sticky", 64'(bus.error_out), 64'd1);
    next_slot();

    // Asynchronous reset in the middle of issue.
    job(64'h0, 32'd5120);
    run(10);
    chk("mid_credits", 64'(bus.credits_out), 64'd22);
    chk("mid_busy", 64'(bus.busy_out), 64'd1);
    bus.enabled_in = 1'b0;
    rstn           = 1'b0;
    #1;
    chk("ar_busy", 64'(bus.busy_out), 64'd0);
    chk("ar_credits", 64'(bus.credits_out), 64'd32);
    chk("ar_valid", 64'(bus.cmd_valid_out), 64'd0);
    chk("ar_error", 64'(bus.error_out), 64'd0);
    next_slot();
    rstn           = 1'b1;
    bus.enabled_in = 1'b1;
    @(negedge clock);
    chk("ar_idle_after", 64'(bus.busy_out), 64'd0);
    chk("ar_ready_after", 64'(bus.job_ready_out), 64'd1);
    next_slot();
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
